// File: rtl/isa_fetch_if.sv
// Fetch-stage bus bundle: instruction memory port, decode handshake
// and execute redirect, seen from the fetch stage (master) side.
interface isa_fetch_if #(
    parameter int AW = 10,
    parameter int DW = 16
);
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_rdata;
    logic [DW-1:0] instr;
    logic [AW-1:0] pc_out;
    logic          instr_valid;
    logic          instr_ready;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          halted;

    modport master (
        output imem_en,
        output imem_addr,
        input  imem_rdata,
        output instr,
        output pc_out,
        output instr_valid,
        input  instr_ready,
        input  redirect_valid,
        input  redirect_pc,
        output halted
    );

    modport slave (
        input  imem_en,
        input  imem_addr,
        output imem_rdata,
        input  instr,
        input  pc_out,
        input  instr_valid,
        output instr_ready,
        output redirect_valid,
        output redirect_pc,
        input  halted
    );
endinterface

// File: rtl/isa_fetch.sv
// Instruction fetch stage: PC, sync-read imem issue, 2-entry response
// queue toward decode, redirect flush and sticky HALT detection.
module isa_fetch #(
    parameter int            AW          = 10,
    parameter int            DW          = 16,
    parameter logic [AW-1:0] RESET_PC    = '0,
    parameter logic [3:0]    HALT_OPCODE = 4'hF
) (
    input logic        clk,
    input logic        reset,
    isa_fetch_if.master bus
);
    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HALT = 1'b1;

    logic [0:0]    state;
    logic [AW-1:0] fetch_pc;
    logic [1:0]    count;
    logic          inflight;
    logic [AW-1:0] inflight_pc;
    logic [AW-1:0] q_pc   [0:1];
    logic [DW-1:0] q_data [0:1];

    logic          transfer;
    logic          halt_xfer;
    logic          room;
    logic          issue;
    logic [1:0]    n_count;
    logic [AW-1:0] n_pc   [0:1];
    logic [DW-1:0] n_data [0:1];

    assign transfer  = bus.instr_valid & bus.instr_ready;
    assign halt_xfer = transfer &&
                       (bus.instr[DW-1:DW-4] == HALT_OPCODE);
    assign room      = (count + {1'b0, inflight}) < 2'd2;
    assign issue     = !reset && (state == RUN) &&
                       !bus.redirect_valid && (room || transfer);

    assign bus.imem_en     = issue;
    assign bus.imem_addr   = fetch_pc;
    assign bus.instr       = q_data[0];
    assign bus.pc_out      = q_pc[0];
    assign bus.instr_valid = (count != 2'd0);
    assign bus.halted      = (state == HALT);

    // Pop shifts the head forward; the arriving word lands right behind
    // whatever survives the pop, so push and pop together keep occupancy.
    always_comb begin
        n_count = count;
        n_pc    = q_pc;
        n_data  = q_data;
        if (transfer) begin
            n_pc[0]   = q_pc[1];
            n_data[0] = q_data[1];
            n_count   = count - 2'd1;
        end
        if (inflight) begin
            n_pc[n_count[0]]   = inflight_pc;
            n_data[n_count[0]] = bus.imem_rdata;
            n_count            = n_count + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            fetch_pc    <= RESET_PC;
            count       <= 2'd0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            q_pc        <= '{default: '0};
            q_data      <= '{default: '0};
        end else begin
            inflight    <= issue;
            inflight_pc <= fetch_pc;
            if (state == HALT) begin
                count    <= 2'd0;
                inflight <= 1'b0;
            end else if (halt_xfer) begin
                state    <= HALT;
                count    <= 2'd0;
                inflight <= 1'b0;
            end else if (bus.redirect_valid) begin
                count    <= 2'd0;
                fetch_pc <= bus.redirect_pc;
            end else begin
                count  <= n_count;
                q_pc   <= n_pc;
                q_data <= n_data;
                if (issue)
                    fetch_pc <= fetch_pc + AW'(1);
            end
        end
    end
endmodule

// File: tb/tb_isa_fetch.sv
// Scoreboard bench for isa_fetch: expected delivery stream derived from
// program order, redirects, HALT and reset; random plus directed cases.
module tb_isa_fetch;
    localparam int AW = 10;
    localparam int DW = 16;
    localparam logic [AW-1:0] RST_PC = '0;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] ins;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    isa_fetch_if #(.AW(AW), .DW(DW)) bus ();
    isa_fetch_if #(.AW(AW), .DW(DW)) wbus ();

    isa_fetch #(.AW(AW), .DW(DW), .RESET_PC(RST_PC),
                .HALT_OPCODE(4'hF))
        dut (.clk(clk), .reset(reset), .bus(bus));

    isa_fetch #(.AW(AW), .DW(DW), .RESET_PC(10'h3FF),
                .HALT_OPCODE(4'hF))
        dut_w (.clk(clk), .reset(reset), .bus(wbus));

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (bus.imem_en)  bus.imem_rdata  <= mem[bus.imem_addr];
        if (wbus.imem_en) wbus.imem_rdata <= mem[wbus.imem_addr];
    end

    int checks = 0;
    int errors = 0;

    function automatic void check(bit ok, string name,
                                  logic [31:0] act, logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endfunction

    ent_t          exp_q [$];
    logic [AW-1:0] fill_pc = '0;
    bit            fill_done = 0;
    bit            exp_halted = 0;
    bit            rst_seen = 0;
    bit            stall_prev = 0;
    logic [AW-1:0] held_pc;
    logic [DW-1:0] held_ins;
    int            idle = 0;

    function automatic void restart(logic [AW-1:0] pc);
        exp_q.delete();
        fill_pc   = pc;
        fill_done = 0;
    endfunction

    function automatic void refill();
        ent_t e;
        while (!fill_done && exp_q.size() < 4) begin
            e.pc  = fill_pc;
            e.ins = mem[fill_pc];
            exp_q.push_back(e);
            if (e.ins[15:12] == 4'hF) fill_done = 1;
            fill_pc = fill_pc + AW'(1);
        end
    endfunction

    always @(negedge clk) begin
        ent_t e;
        bit xfer;
        bit halt_x;
        if (reset) begin
            check(!bus.imem_en, "en_in_reset", bus.imem_en, 0);
            restart(RST_PC);
            exp_halted = 0;
            rst_seen   = 1;
            stall_prev = 0;
            idle       = 0;
        end else begin
            if (rst_seen) begin
                check(!bus.instr_valid, "valid_after_reset",
                      bus.instr_valid, 0);
                check(!bus.halted, "halted_after_reset", bus.halted, 0);
                rst_seen = 0;
            end
            check(bus.halted == exp_halted, "halted",
                  bus.halted, exp_halted);
            if (exp_halted)
                check(!bus.imem_en && !bus.instr_valid, "idle_when_halted",
                      {bus.imem_en, bus.instr_valid}, 0);
            else if (bus.redirect_valid)
                check(!bus.imem_en, "no_issue_on_redirect",
                      bus.imem_en, 0);
            if (stall_prev)
                check(bus.instr_valid && bus.pc_out == held_pc &&
                      bus.instr == held_ins, "hold_stable",
                      {bus.instr_valid, bus.pc_out}, {1'b1, held_pc});
            xfer   = bus.instr_valid && bus.instr_ready;
            halt_x = 0;
            if (xfer) begin
                if (exp_q.size() == 0) begin
                    check(0, "unexpected_xfer", bus.pc_out, 0);
                end else begin
                    e = exp_q.pop_front();
                    check(bus.pc_out == e.pc, "xfer_pc", bus.pc_out, e.pc);
                    check(bus.instr == e.ins, "xfer_instr",
                          bus.instr, e.ins);
                    halt_x = (e.ins[15:12] == 4'hF);
                end
            end
            if (bus.instr_ready && !exp_halted &&
                !bus.redirect_valid && !xfer)
                idle++;
            else
                idle = 0;
            if (idle > 5) begin
                check(0, "progress_timeout", idle, 5);
                idle = 0;
            end
            stall_prev = bus.instr_valid && !bus.instr_ready &&
                         !bus.redirect_valid && !exp_halted;
            held_pc  = bus.pc_out;
            held_ins = bus.instr;
            if (halt_x) begin
                exp_halted = 1;
                exp_q.delete();
                fill_done = 1;
            end else if (bus.redirect_valid && !exp_halted) begin
                restart(bus.redirect_pc);
            end
        end
        refill();
    end

    int wn = 0;
    bit wdone = 0;
    always @(negedge clk) begin
        if (!reset && !wdone && wbus.instr_valid) begin
            if (wn == 0) begin
                check(wbus.pc_out == 10'h3FF, "wrap_pc0",
                      wbus.pc_out, 10'h3FF);
                check(wbus.instr == mem[10'h3FF], "wrap_ins0",
                      wbus.instr, mem[10'h3FF]);
            end else begin
                check(wbus.pc_out == 10'h000, "wrap_pc1",
                      wbus.pc_out, 0);
                check(wbus.instr == mem[0], "wrap_ins1",
                      wbus.instr, mem[0]);
                wdone = 1;
            end
            wn++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(int n);
        reset = 1'b1;
        repeat (n) step();
        reset = 1'b0;
    endtask

    task automatic wait_pc(logic [AW-1:0] pc, string name);
        int n = 0;
        @(negedge clk);
        while (!(bus.instr_valid && bus.pc_out == pc) && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (n >= 20) check(0, name, bus.pc_out, pc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        for (int i = 0; i < (1 << AW); i++)
            mem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
        mem[0] = 16'h1111;
        mem[1] = 16'h2222;
        mem[2] = 16'h3333;
        mem[3] = 16'hF000;
        mem[10'h3FF] = 16'h7ABC;
        for (int i = 0; i < 4; i++)
            mem[10'h100 + i] = 16'h5100 + 16'(i);
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        wbus.instr_ready    = 1'b1;
        wbus.redirect_valid = 1'b0;
        wbus.redirect_pc    = '0;

        // sequential fetch and first-delivery latency
        step();
        bus.instr_ready = 1'b1;
        do_reset(2);
        n = 0;
        @(negedge clk);
        while (!bus.instr_valid && n < 10) begin
            n++;
            @(negedge clk);
        end
        check(n == 2, "first_latency", n, 2);
        repeat (10) step();
        check(bus.halted, "seq_halted", bus.halted, 1);

        // backpressure with head at 001
        do_reset(2);
        wait_pc(10'h000, "bp_wait_000");
        step();
        bus.instr_ready = 1'b0;
        repeat (2) step();
        @(negedge clk);
        check(!bus.imem_en, "bp_no_issue", bus.imem_en, 0);
        check(bus.pc_out == 10'h001, "bp_pc", bus.pc_out, 1);
        check(bus.instr == 16'h2222, "bp_instr", bus.instr, 16'h2222);
        step();
        bus.instr_ready = 1'b1;
        repeat (10) step();

        // redirect while 002 is in flight
        do_reset(2);
        repeat (3) step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 10'h100;
        step();
        bus.redirect_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.instr_valid && n < 10) begin
            n++;
            @(negedge clk);
        end
        check(bus.pc_out == 10'h100, "redir_pc", bus.pc_out, 10'h100);
        check(bus.instr == mem[10'h100], "redir_instr",
              bus.instr, mem[10'h100]);
        repeat (4) step();

        // halt wins over a same-cycle redirect
        do_reset(2);
        n = 0;
        while (!(bus.instr_valid && bus.pc_out == 10'h003) && n < 20) begin
            step();
            n++;
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 10'h200;
        step();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check(bus.halted, "halt_precedence", bus.halted, 1);
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 10'h100;
        @(negedge clk);
        check(!bus.imem_en, "halted_redirect_en", bus.imem_en, 0);
        step();
        bus.redirect_valid = 1'b0;
        repeat (3) step();

        // reset with two entries queued
        bus.instr_ready = 1'b0;
        do_reset(2);
        repeat (4) step();
        do_reset(1);
        @(negedge clk);
        check(!bus.instr_valid, "mid_reset_valid", bus.instr_valid, 0);
        check(!bus.halted, "mid_reset_halted", bus.halted, 0);
        step();
        bus.instr_ready = 1'b1;
        wait_pc(RST_PC, "mid_reset_restart");
        check(bus.instr == mem[RST_PC], "mid_reset_instr",
              bus.instr, mem[RST_PC]);
        repeat (4) step();

        // randomized episodes
        for (int ep = 0; ep < 16; ep++) begin
            reset = 1'b1;
            for (int i = 0; i < (1 << AW); i++) begin
                if ($urandom_range(0, 39) == 0)
                    mem[i] = {4'hF, 12'($urandom)};
                else
                    mem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
            end
            do_reset(1 + $urandom_range(0, 2));
            repeat (300) begin
                bus.instr_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 19) == 0) begin
                    bus.redirect_valid = 1'b1;
                    bus.redirect_pc    = AW'($urandom);
                end else begin
                    bus.redirect_valid = 1'b0;
                end
                reset = ($urandom_range(0, 199) == 0);
                step();
            end
            bus.redirect_valid = 1'b0;
            reset = 1'b0;
        end

        check(wdone, "wrap_done", wdone, 1);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/isa_fetch.md
Name: isa_fetch

Overview:
Instruction fetch stage for the isa core, directly upstream of decode/execute. It owns the program counter and issues word reads to a synchronous-read instruction memory. Responses are buffered in a 2-entry queue and delivered to decode over a valid/ready handshake. It also handles control-flow redirects and detects HALT, which drives the core's halted output.

Parameters:
AW, 10, instruction address width (word-addressed PC)
DW, 16, instruction width
RESET_PC, 0, fetch address after reset (AW bits)
HALT_OPCODE, 4'hF, value of instr[DW-1:DW-4] that marks HALT

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
imem_en  output  1  read request to instruction memory this cycle
imem_addr  output  AW  word address of the read
imem_rdata  input  DW  read data, valid exactly one cycle after imem_en=1
instr  output  DW  instruction at queue head
pc_out  output  AW  address of instr
instr_valid  output  1  queue head valid
instr_ready  input  1  decode accepts; transfer = instr_valid & instr_ready
redirect_valid  input  1  execute requests fetch from redirect_pc
redirect_pc  input  AW  redirect target
halted  output  1  HALT retired to decode; sticky until reset

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, sampled on rising clk.
- Reset state:
  - fetch_pc=RESET_PC; queue empty; no read in flight.
  - instr_valid=0, instr=0, pc_out=0, halted=0, imem_en=0.
  - Reset asserted mid-operation discards the queue and any in-flight response. The next cycle behaves as the first cycle after reset.
- Issue:
  - imem_en=1 when !reset, !halted, !redirect_valid, and (occupancy + inflight < 2, or a transfer occurs this cycle).
  - imem_en is combinational from instr_ready.
  - imem_addr=fetch_pc. On issue, fetch_pc <= fetch_pc+1, wrapping modulo 2^AW (0x3FF -> 0x000).
- Response: the cycle after an issue, imem_rdata and its address are pushed into the queue tail. No drops and no overflow are guaranteed by the issue rule.
- Output:
  - instr/pc_out/instr_valid come from the queue head (registered). instr and pc_out are held stable while instr_valid=1 and instr_ready=0.
  - Latency: first instr_valid 2 cycles after the first issue.
  - Throughput: 1 instr/cycle with instr_ready held high.
- Simultaneous push and pop: allowed at any occupancy, and occupancy is unchanged.
- Redirect (redirect_valid=1, !halted):
  - A transfer in the same cycle still completes.
  - The queue and any in-flight response (arriving next cycle) are discarded.
  - fetch_pc <= redirect_pc. No issue occurs that cycle, and issue resumes at redirect_pc next cycle.
  - Consecutive redirects: the last one wins.
- Halt:
  - On a transfer whose instr[DW-1:DW-4]==HALT_OPCODE, halted <= 1 next cycle.
  - The queue and in-flight response are flushed, instr_valid=0, and imem_en stays 0.
  - redirect_valid is ignored while halted. Only reset clears halted.
  - HALT arriving in the same transfer cycle as redirect_valid: halt wins, and the redirect is ignored.
- States:
  - RUN: normal issue and deliver.
  - HALT: idle.
  - Transitions: RUN -> HALT on HALT transfer; any state -> RUN on reset.

Test Plan:
- Sequential fetch: imem[0..3] = 1111, 2222, 3333, F000; ready=1 → pc_out 000, 001, 002, 003 on consecutive cycles starting 2 cycles after reset release; halted=1 the cycle after 003 transfers; imem_en=0 thereafter.
- Backpressure: ready=0 for 3 cycles with head at 001 → instr=2222 and pc_out=001 held; imem_en=0 once occupancy+inflight=2; on ready=1, 001 and 002 transfer back-to-back with no loss or duplicate.
- Redirect: redirect_valid=1, redirect_pc=0x100 while 002 is in flight → 002 never presented; next instr_valid has pc_out=0x100 with imem[0x100]; issue resumes at 0x101.
- Wrap: RESET_PC=0x3FF → pc_out 3FF then 000.
- Halt precedence: redirect_valid=1 in the HALT transfer cycle → halted=1 and no fetch from redirect_pc. Redirect pulsed while halted → no imem_en.
- Reset mid-stream: reset for 1 cycle with 2 entries queued → instr_valid=0 and halted=0 next cycle; fetch restarts at RESET_PC and first delivers imem[RESET_PC].
